// File: rtl/imem_arbiter.sv
// Shares one synchronous-read instruction memory port between CPU fetch (priority)
// and a debug reader with aging, routing each 1-cycle-latency response to its issuer.
module imem_arbiter #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_gnt,
   output logic              fetch_rvalid,
   output logic [DATA_W-1:0] fetch_rdata,
   input  logic              dbg_req,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic [ADDR_W-1:0] mem_a,
   input  logic [DATA_W-1:0] mem_rd
);

   localparam int unsigned CNT_W = 4;

   logic [CNT_W-1:0]  wait_cnt;
   logic [CNT_W-1:0]  wait_cnt_nxt;
   logic              aged;
   logic              own_f;
   logic              own_d;
   logic [DATA_W-1:0] hold_f;
   logic [DATA_W-1:0] hold_d;

   // Grant, address mux and aging counter next value
   always_comb begin
      aged         = (wait_cnt == CNT_W'(MAX_WAIT));
      dbg_gnt      = dbg_req & (~fetch_req | aged);
      fetch_gnt    = fetch_req & ~dbg_gnt;
      mem_a        = dbg_gnt ? dbg_addr : fetch_addr;
      wait_cnt_nxt = wait_cnt;
      if (dbg_gnt || !dbg_req) begin
         wait_cnt_nxt = '0;
      end else if (!aged) begin
         wait_cnt_nxt = wait_cnt + CNT_W'(1);
      end
   end

   // Owner of the read in flight, plus last delivered word per port
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= '0;
         own_f    <= 1'b0;
         own_d    <= 1'b0;
         hold_f   <= '0;
         hold_d   <= '0;
      end else begin
         wait_cnt <= wait_cnt_nxt;
         own_f    <= fetch_gnt;
         own_d    <= dbg_gnt;
         if (own_f) hold_f <= mem_rd;
         if (own_d) hold_d <= mem_rd;
      end
   end

   assign fetch_rvalid = own_f;
   assign dbg_rvalid   = own_d;
   assign fetch_rdata  = own_f ? mem_rd : hold_f;
   assign dbg_rdata    = own_d ? mem_rd : hold_d;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed self-checking bench for imem_arbiter with a behavioural synchronous RAM.
module tb_imem_arbiter;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_gnt;
   logic              fetch_rvalid;
   logic [DATA_W-1:0] fetch_rdata;
   logic              dbg_req;
   logic [ADDR_W-1:0] dbg_addr;
   logic              dbg_gnt;
   logic              dbg_rvalid;
   logic [DATA_W-1:0] dbg_rdata;
   logic [ADDR_W-1:0] mem_a;
   logic [DATA_W-1:0] mem_rd;

   logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

   int total = 0;
   int bad   = 0;

   imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
      .clk(clk), .reset(reset),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
      .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
      .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
      .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .mem_a(mem_a), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   always @(posedge clk) mem_rd <= ram[mem_a];

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; fetch_req = 1'b0; dbg_req = 1'b0;
      fetch_addr = 16'h0003; dbg_addr = 16'h0044;
      #1;
      total++; if (fetch_rvalid !== 1'b0) begin bad++; $display("FAIL rst_frvalid got %b exp 0", fetch_rvalid); end
      total++; if (dbg_rvalid !== 1'b0) begin bad++; $display("FAIL rst_drvalid got %b exp 0", dbg_rvalid); end
      total++; if (fetch_rdata !== 32'h0) begin bad++; $display("FAIL rst_frdata got %h exp 0", fetch_rdata); end
      total++; if (dbg_rdata !== 32'h0) begin bad++; $display("FAIL rst_drdata got %h exp 0", dbg_rdata); end
      total++; if (mem_a !== 16'h0003) begin bad++; $display("FAIL rst_mem_a got %h exp 0003", mem_a); end
      dbg_req = 1'b1; #1;
      total++; if (dbg_gnt !== 1'b1 || mem_a !== 16'h0044) begin bad++; $display("FAIL rst_dgnt got %b/%h exp 1/0044", dbg_gnt, mem_a); end
      fetch_req = 1'b1; #1;
      total++; if (fetch_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin bad++; $display("FAIL rst_prio got f=%b d=%b exp f=1 d=0", fetch_gnt, dbg_gnt); end
      tick(); tick();
      total++; if (fetch_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin bad++; $display("FAIL rst_norecord got f=%b d=%b exp 0/0", fetch_rvalid, dbg_rvalid); end
      fetch_req = 1'b0; dbg_req = 1'b0;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_fetch_only();
      for (int i = 0; i < 4; i++) begin
         fetch_req = 1'b1; fetch_addr = 16'(i); #1;
         total++; if (fetch_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin bad++; $display("FAIL fo_gnt[%0d] got f=%b d=%b exp 1/0", i, fetch_gnt, dbg_gnt); end
         tick();
         total++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'h100 + 32'(i)) begin bad++; $display("FAIL fo_resp[%0d] got %b/%h exp 1/%h", i, fetch_rvalid, fetch_rdata, 32'h100 + 32'(i)); end
         total++; if (dbg_rvalid !== 1'b0) begin bad++; $display("FAIL fo_drvalid[%0d] got %b exp 0", i, dbg_rvalid); end
      end
      fetch_req = 1'b0;
      tick();
   endtask

   task automatic test_hold();
      fetch_req = 1'b1; fetch_addr = 16'h0005;
      tick();
      fetch_req = 1'b0;
      total++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL hold_pulse got %b/%h exp 1/deadbeef", fetch_rvalid, fetch_rdata); end
      for (int i = 0; i < 6; i++) begin
         fetch_addr = 16'(i + 1);
         tick();
         total++; if (fetch_rvalid !== 1'b0 || fetch_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL hold[%0d] got %b/%h exp 0/deadbeef", i, fetch_rvalid, fetch_rdata); end
      end
   endtask

   task automatic test_aging();
      bit exp_d;
      fetch_req = 1'b1; dbg_req = 1'b1;
      fetch_addr = 16'h0030; dbg_addr = 16'h0040;
      for (int c = 0; c < 10; c++) begin
         exp_d = ((c % 5) == 4);
         #1;
         total++; if (dbg_gnt !== exp_d || fetch_gnt !== !exp_d) begin bad++; $display("FAIL age_gnt[%0d] got f=%b d=%b exp d=%b", c, fetch_gnt, dbg_gnt, exp_d); end
         total++; if (mem_a !== (exp_d ? 16'h0040 : 16'h0030)) begin bad++; $display("FAIL age_mem_a[%0d] got %h", c, mem_a); end
         tick();
         if (exp_d) begin
            total++; if (dbg_rvalid !== 1'b1 || fetch_rvalid !== 1'b0 || dbg_rdata !== 32'h140) begin bad++; $display("FAIL age_dresp[%0d] got d=%b f=%b %h exp 1/0/140", c, dbg_rvalid, fetch_rvalid, dbg_rdata); end
         end else begin
            total++; if (fetch_rvalid !== 1'b1 || dbg_rvalid !== 1'b0 || fetch_rdata !== 32'h130) begin bad++; $display("FAIL age_fresp[%0d] got f=%b d=%b %h exp 1/0/130", c, fetch_rvalid, dbg_rvalid, fetch_rdata); end
         end
      end
      fetch_req = 1'b0; dbg_req = 1'b0;
      tick();
   endtask

   task automatic test_idle_debug();
      fetch_req = 1'b0; dbg_req = 1'b1; dbg_addr = 16'h00A0;
      for (int i = 0; i < 2; i++) begin
         #1;
         total++; if (dbg_gnt !== 1'b1 || fetch_gnt !== 1'b0 || mem_a !== 16'h00A0) begin bad++; $display("FAIL idle_gnt[%0d] got d=%b f=%b %h exp 1/0/00a0", i, dbg_gnt, fetch_gnt, mem_a); end
         total++; if (dut.wait_cnt !== 4'd0) begin bad++; $display("FAIL idle_wait[%0d] got %0d exp 0", i, dut.wait_cnt); end
         tick();
         total++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'h1A0) begin bad++; $display("FAIL idle_resp[%0d] got %b/%h exp 1/1a0", i, dbg_rvalid, dbg_rdata); end
         total++; if (fetch_rvalid !== 1'b0 || fetch_rdata !== 32'h130) begin bad++; $display("FAIL idle_fhold[%0d] got %b/%h exp 0/130", i, fetch_rvalid, fetch_rdata); end
      end
      dbg_req = 1'b0;
      tick();
   endtask

   task automatic test_interleave();
      bit                is_d [3];
      logic [ADDR_W-1:0] adr [3];
      logic [DATA_W-1:0] fh;
      logic [DATA_W-1:0] dh;
      is_d[0] = 1'b0; adr[0] = 16'h0010;
      is_d[1] = 1'b1; adr[1] = 16'h0020;
      is_d[2] = 1'b0; adr[2] = 16'h0011;
      fh = 32'h130; dh = 32'h1A0;
      for (int i = 0; i < 3; i++) begin
         fetch_req = !is_d[i]; dbg_req = is_d[i];
         fetch_addr = is_d[i] ? 16'h0077 : adr[i];
         dbg_addr   = is_d[i] ? adr[i] : 16'h0066;
         tick();
         if (is_d[i]) dh = 32'h100 + 32'(adr[i]);
         else         fh = 32'h100 + 32'(adr[i]);
         total++; if (fetch_rvalid !== !is_d[i] || dbg_rvalid !== is_d[i]) begin bad++; $display("FAIL il_valid[%0d] got f=%b d=%b", i, fetch_rvalid, dbg_rvalid); end
         total++; if (fetch_rdata !== fh || dbg_rdata !== dh) begin bad++; $display("FAIL il_data[%0d] got f=%h d=%h exp f=%h d=%h", i, fetch_rdata, dbg_rdata, fh, dh); end
      end
      fetch_req = 1'b0; dbg_req = 1'b0;
      tick();
   endtask

   task automatic test_reset_midread();
      fetch_req = 1'b1; fetch_addr = 16'h0007; #1;
      total++; if (fetch_gnt !== 1'b1) begin bad++; $display("FAIL mr_gnt got %b exp 1", fetch_gnt); end
      reset = 1'b1; #1;
      total++; if (fetch_rvalid !== 1'b0 || fetch_rdata !== 32'h0 || dbg_rdata !== 32'h0) begin bad++; $display("FAIL mr_async got %b/%h/%h exp 0/0/0", fetch_rvalid, fetch_rdata, dbg_rdata); end
      tick();
      total++; if (fetch_rvalid !== 1'b0 || fetch_rdata !== 32'h0) begin bad++; $display("FAIL mr_drop got %b/%h exp 0/0", fetch_rvalid, fetch_rdata); end
      fetch_req = 1'b0;
      reset = 1'b0;
      tick();
      fetch_req = 1'b1; fetch_addr = 16'h0002;
      tick();
      fetch_req = 1'b0;
      total++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'h102) begin bad++; $display("FAIL mr_after got %b/%h exp 1/102", fetch_rvalid, fetch_rdata); end
      tick();
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 32'(i) + 32'h100;
      ram[5] = 32'hDEADBEEF;
      @(negedge clk);
      test_reset();
      test_fetch_only();
      test_hold();
      test_aging();
      test_idle_debug();
      test_interleave();
      test_reset_midread();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
